// File: rtl/carry_chain_pipe_if.sv
// Handshake and data bundle for carry_chain_pipe.
// The IN_CHAIN member exists only when CARRY_CASCADE_EN is defined.
interface carry_chain_pipe_if #(
    parameter int WIDTH = 16
);
    logic             IN_VALID;
    logic             IN_READY;
    logic             CI;
    logic             CYINIT;
    logic [WIDTH-1:0] DI;
    logic [WIDTH-1:0] S;
`ifdef CARRY_CASCADE_EN
    logic             IN_CHAIN;
`endif
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] CO;
    logic [WIDTH-1:0] O;

`ifdef CARRY_CASCADE_EN
    modport master (
        output IN_VALID, CI, CYINIT, DI, S, IN_CHAIN, OUT_READY,
        input  IN_READY, OUT_VALID, CO, O
    );
    modport slave (
        input  IN_VALID, CI, CYINIT, DI, S, IN_CHAIN, OUT_READY,
        output IN_READY, OUT_VALID, CO, O
    );
`else
    modport master (
        output IN_VALID, CI, CYINIT, DI, S, OUT_READY,
        input  IN_READY, OUT_VALID, CO, O
    );
    modport slave (
        input  IN_VALID, CI, CYINIT, DI, S, OUT_READY,
        output IN_READY, OUT_VALID, CO, O
    );
`endif
endinterface

// File: rtl/carry_chain_pipe.sv
// Pipelined WIDTH-bit carry-mux/XOR chain, one register stage per SEG_BITS segment.
// Optional CARRY_CASCADE_EN: IN_CHAIN takes c0 from the previous word's CO[WIDTH-1].
module carry_chain_pipe #(
    parameter int WIDTH    = 16,
    parameter int SEG_BITS = 4
) (
    input logic              CLK,
    input logic              RST_N,
    carry_chain_pipe_if.slave bus
);
    localparam int NSEG = WIDTH / SEG_BITS;

    // A chained word's c0 is unknown until its predecessor leaves the last
    // segment, so carries are tracked as "value with c0=0" plus "depends on c0".
    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] di;
        logic [WIDTH-1:0] o;
        logic [WIDTH-1:0] co;
        logic [WIDTH-1:0] oDep;
        logic [WIDTH-1:0] coDep;
        logic             cVal;
        logic             cDep;
    } stage_t;

    function automatic stage_t resolveSeg(input stage_t p, input int seg);
        stage_t q;
        logic   c;
        logic   d;
        int     i;
        q = p;
        c = p.cVal;
        d = p.cDep;
        for (int j = 0; j < SEG_BITS; j++) begin
            i         = seg * SEG_BITS + j;
            q.o[i]    = p.s[i] ^ c;
            q.oDep[i] = d;
            if (p.s[i]) begin
                q.co[i]    = c;
                q.coDep[i] = d;
            end else begin
                q.co[i]    = p.di[i];
                q.coDep[i] = 1'b0;
            end
            c = q.co[i];
            d = q.coDep[i];
        end
        q.cVal = c;
        q.cDep = d;
        return q;
    endfunction

    stage_t          r_stage [NSEG];
    logic [NSEG-1:0] r_valid;

    stage_t          w_inWord;
    stage_t          w_next [NSEG];
    stage_t          w_final;
    logic [NSEG-1:0] w_adv;
    logic [NSEG-1:0] w_load;
    logic            w_inXfer;
    logic            w_c0Val;
    logic            w_c0Dep;

`ifdef CARRY_CASCADE_EN
    logic r_chainCarry;

    always_comb begin
        w_c0Val = bus.IN_CHAIN ? 1'b0 : (bus.CI | bus.CYINIT);
        w_c0Dep = bus.IN_CHAIN;
    end
`else
    assign w_c0Val = bus.CI | bus.CYINIT;
    assign w_c0Dep = 1'b0;
`endif

    always_comb begin
        w_inWord      = '0;
        w_inWord.s    = bus.S;
        w_inWord.di   = bus.DI;
        w_inWord.cVal = w_c0Val;
        w_inWord.cDep = w_c0Dep;
    end

    always_comb begin
        w_next[0] = resolveSeg(w_inWord, 0);
        for (int k = 1; k < NSEG; k++) begin
            w_next[k] = resolveSeg(r_stage[k-1], k);
        end
    end

    // The last stage folds in the forwarded carry of the previous word.
    always_comb begin
        w_final = w_next[NSEG-1];
`ifdef CARRY_CASCADE_EN
        w_final.co    = w_final.co | (w_final.coDep & {WIDTH{r_chainCarry}});
        w_final.o     = w_final.o ^ (w_final.oDep & {WIDTH{r_chainCarry}});
        w_final.coDep = '0;
        w_final.oDep  = '0;
        w_final.cDep  = 1'b0;
        w_final.cVal  = w_final.co[WIDTH-1];
`endif
    end

    always_comb begin
        logic downFree;
        logic advK;
        downFree = bus.OUT_READY;
        w_adv    = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            advK     = r_valid[k] & downFree;
            w_adv[k] = advK;
            downFree = !r_valid[k] | advK;
        end
    end

    assign bus.IN_READY = !r_valid[0] | w_adv[0];
    assign w_inXfer     = bus.IN_VALID & bus.IN_READY;

    always_comb begin
        w_load    = '0;
        w_load[0] = w_inXfer;
        for (int k = 1; k < NSEG; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= '0;
            for (int k = 0; k < NSEG; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_stage[k] <= (k == NSEG - 1) ? w_final : w_next[k];
                end else if (w_adv[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef CARRY_CASCADE_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_chainCarry <= 1'b0;
        end else if (w_load[NSEG-1]) begin
            r_chainCarry <= w_final.co[WIDTH-1];
        end
    end
`endif

    assign bus.OUT_VALID = r_valid[NSEG-1];
    assign bus.CO        = r_stage[NSEG-1].co;
    assign bus.O         = r_stage[NSEG-1].o;
endmodule

// File: tb/tb_carry_chain_pipe.sv
// Randomised self-checking bench for carry_chain_pipe against an adder-based model.
// The chained-carry scenario is compiled only with CARRY_CASCADE_EN.
module tb_carry_chain_pipe;
    localparam int WIDTH    = 16;
    localparam int SEG_BITS = 4;
    localparam int NSEG     = WIDTH / SEG_BITS;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;
    logic [2*WIDTH-1:0] expQ [$];

    always #5 CLK = ~CLK;

    carry_chain_pipe_if #(.WIDTH(WIDTH)) bus ();

    carry_chain_pipe #(.WIDTH(WIDTH), .SEG_BITS(SEG_BITS)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Chain with selects S and data DI equals the sum A+B+c0 with A=DI, B=DI^S.
    function automatic logic [2*WIDTH-1:0] refModel(input logic [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0] di,
                                                    input logic c0);
        logic [WIDTH:0]   a;
        logic [WIDTH:0]   b;
        logic [WIDTH:0]   cin;
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   m;
        logic [WIDTH:0]   part;
        logic [WIDTH-1:0] co;
        a   = {1'b0, di};
        b   = {1'b0, di ^ s};
        cin = {{WIDTH{1'b0}}, c0};
        sum = a + b + cin;
        for (int i = 0; i < WIDTH; i++) begin
            m     = ((WIDTH+1)'(1) << (i + 1)) - (WIDTH+1)'(1);
            part  = (a & m) + (b & m) + cin;
            co[i] = part[i+1];
        end
        return {co, sum[WIDTH-1:0]};
    endfunction

    task automatic nextCycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic driveWord(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] di,
                             input logic ci, input logic cyi);
        bus.S        = s;
        bus.DI       = di;
        bus.CI       = ci;
        bus.CYINIT   = cyi;
        bus.IN_VALID = 1'b1;
    endtask

    task automatic randomAdd(output logic [WIDTH-1:0] s, output logic [WIDTH-1:0] di,
                             output logic ci, output logic cyi);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        s   = a ^ b;
        di  = a;
        ci  = 1'($urandom);
        cyi = 1'($urandom);
    endtask

    task automatic test_reset;
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.S         = '0;
        bus.DI        = '0;
        bus.CI        = 1'b0;
        bus.CYINIT    = 1'b0;
`ifdef CARRY_CASCADE_EN
        bus.IN_CHAIN  = 1'b0;
`endif
        #1 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkCount++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", bus.OUT_VALID);
        else passCount++;
        checkCount++;
        if (bus.CO !== '0) $display("FAIL reset_co: got %h, expected 0000", bus.CO);
        else passCount++;
        checkCount++;
        if (bus.O !== '0) $display("FAIL reset_o: got %h, expected 0000", bus.O);
        else passCount++;
        checkCount++;
        if (bus.IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b, expected 1", bus.IN_READY);
        else passCount++;
        @(negedge CLK) RST_N = 1'b1;
        nextCycle();
    endtask

    task automatic test_basic;
        logic [WIDTH-1:0] heldCo;
        logic [WIDTH-1:0] heldO;
        bus.OUT_READY = 1'b1;
        driveWord(16'hFFFE, 16'hFFFF, 1'b0, 1'b0);
        #1;
        checkCount++;
        if (bus.IN_READY !== 1'b1) $display("FAIL basic_in_ready: got %b, expected 1", bus.IN_READY);
        else passCount++;
        nextCycle();
        bus.IN_VALID = 1'b0;
        for (int e = 0; e < NSEG; e++) begin
            checkCount++;
            if (bus.OUT_VALID !== (e == NSEG - 1))
                $display("FAIL basic_latency[%0d]: got OUT_VALID=%b, expected %b", e, bus.OUT_VALID, (e == NSEG - 1));
            else passCount++;
            if (e < NSEG - 1) nextCycle();
        end
        checkCount++;
        if (bus.O !== 16'h0000) $display("FAIL basic_o: got %h, expected 0000", bus.O);
        else passCount++;
        checkCount++;
        if (bus.CO !== 16'hFFFF) $display("FAIL basic_co: got %h, expected ffff", bus.CO);
        else passCount++;
        heldCo = 16'hFFFF;
        heldO  = 16'h0000;
        nextCycle();
        checkCount++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL basic_single: got OUT_VALID=%b, expected 0", bus.OUT_VALID);
        else passCount++;
        checkCount++;
        if ({bus.CO, bus.O} !== {heldCo, heldO})
            $display("FAIL basic_hold: got CO=%h O=%h, expected CO=%h O=%h", bus.CO, bus.O, heldCo, heldO);
        else passCount++;
    endtask

    task automatic test_streaming;
        logic [WIDTH-1:0]   s;
        logic [WIDTH-1:0]   di;
        logic               ci;
        logic               cyi;
        logic [2*WIDTH-1:0] e;
        int sent, got, firstCyc, lastCyc;
        sent = 0; got = 0; firstCyc = -1; lastCyc = -1;
        expQ.delete();
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (sent < 8) begin
                randomAdd(s, di, ci, cyi);
                driveWord(s, di, ci, cyi);
            end else bus.IN_VALID = 1'b0;
            #1;
            if (bus.OUT_VALID) begin
                checkCount++;
                if (expQ.size() == 0) $display("FAIL stream_extra: got CO=%h O=%h, expected no output", bus.CO, bus.O);
                else begin
                    e = expQ.pop_front();
                    if ({bus.CO, bus.O} !== e)
                        $display("FAIL stream_data[%0d]: got CO=%h O=%h, expected CO=%h O=%h",
                                 got, bus.CO, bus.O, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                    else passCount++;
                end
                if (firstCyc < 0) firstCyc = cyc;
                lastCyc = cyc;
                got++;
            end
            if (bus.IN_VALID) begin
                checkCount++;
                if (bus.IN_READY !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b, expected 1", cyc, bus.IN_READY);
                else passCount++;
                if (bus.IN_READY) begin
                    expQ.push_back(refModel(s, di, ci | cyi));
                    sent++;
                end
            end
            nextCycle();
        end
        bus.IN_VALID = 1'b0;
        checkCount++;
        if (got != 8) $display("FAIL stream_count: got %0d results, expected 8", got);
        else passCount++;
        checkCount++;
        if (lastCyc - firstCyc != 7) $display("FAIL stream_spacing: got span %0d, expected 7", lastCyc - firstCyc);
        else passCount++;
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0]   s;
        logic [WIDTH-1:0]   di;
        logic               ci;
        logic               cyi;
        logic [2*WIDTH-1:0] e;
        int sent, got;
        sent = 0; got = 0;
        expQ.delete();
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            bus.OUT_READY = (cyc >= 8);
            if (sent < 6) begin
                randomAdd(s, di, ci, cyi);
                driveWord(s, di, ci, cyi);
            end else bus.IN_VALID = 1'b0;
            #1;
            if (cyc < 8) begin
                checkCount++;
                if (bus.IN_READY !== (sent < NSEG))
                    $display("FAIL bp_fill[%0d]: got IN_READY=%b, expected %b", cyc, bus.IN_READY, (sent < NSEG));
                else passCount++;
            end
            if (cyc == 8) begin
                checkCount++;
                if (bus.IN_READY !== 1'b1) $display("FAIL bp_full_shift: got IN_READY=%b, expected 1", bus.IN_READY);
                else passCount++;
            end
            if (bus.OUT_VALID) begin
                checkCount++;
                if (expQ.size() == 0) $display("FAIL bp_extra: got CO=%h O=%h, expected no output", bus.CO, bus.O);
                else begin
                    e = bus.OUT_READY ? expQ.pop_front() : expQ[0];
                    if ({bus.CO, bus.O} !== e)
                        $display("FAIL bp_data[%0d]: got CO=%h O=%h, expected CO=%h O=%h",
                                 cyc, bus.CO, bus.O, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                    else passCount++;
                end
                if (bus.OUT_READY) got++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                expQ.push_back(refModel(s, di, ci | cyi));
                sent++;
            end
            nextCycle();
        end
        bus.IN_VALID = 1'b0;
        checkCount++;
        if (got != 6 || expQ.size() != 0)
            $display("FAIL bp_count: got %0d results with %0d pending, expected 6 with 0", got, expQ.size());
        else passCount++;
        nextCycle();
        checkCount++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL bp_drained: got OUT_VALID=%b, expected 0", bus.OUT_VALID);
        else passCount++;
    endtask

    task automatic test_constants;
        logic [WIDTH-1:0]   sTab  [4];
        logic [WIDTH-1:0]   dTab  [4];
        logic               ciTab [4];
        logic               cyTab [4];
        logic [2*WIDTH-1:0] e;
        int sent, got;
        sTab[0] = 16'hFFFF; dTab[0] = 16'h0000; ciTab[0] = 1'b0; cyTab[0] = 1'b1;
        sTab[1] = 16'hFFFF; dTab[1] = 16'h0000; ciTab[1] = 1'b1; cyTab[1] = 1'b0;
        sTab[2] = 16'h0000; dTab[2] = 16'hA5A5; ciTab[2] = 1'b0; cyTab[2] = 1'b0;
        sTab[3] = 16'h0000; dTab[3] = 16'hA5A5; ciTab[3] = 1'b1; cyTab[3] = 1'b1;
        sent = 0; got = 0;
        expQ.delete();
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            if (sent < 4) driveWord(sTab[sent], dTab[sent], ciTab[sent], cyTab[sent]);
            else bus.IN_VALID = 1'b0;
            #1;
            if (bus.OUT_VALID) begin
                checkCount++;
                if (expQ.size() == 0) $display("FAIL const_extra: got CO=%h O=%h, expected no output", bus.CO, bus.O);
                else begin
                    e = expQ.pop_front();
                    if ({bus.CO, bus.O} !== e)
                        $display("FAIL const_data[%0d]: got CO=%h O=%h, expected CO=%h O=%h",
                                 got, bus.CO, bus.O, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                    else passCount++;
                end
                if (got < 2) begin
                    checkCount++;
                    if ({bus.CO, bus.O} !== {16'hFFFF, 16'h0000})
                        $display("FAIL const_prop[%0d]: got CO=%h O=%h, expected CO=ffff O=0000", got, bus.CO, bus.O);
                    else passCount++;
                end else begin
                    checkCount++;
                    if (bus.CO !== 16'hA5A5) $display("FAIL const_gen[%0d]: got CO=%h, expected a5a5", got, bus.CO);
                    else passCount++;
                end
                got++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                expQ.push_back(refModel(sTab[sent], dTab[sent], ciTab[sent] | cyTab[sent]));
                sent++;
            end
            nextCycle();
        end
        bus.IN_VALID = 1'b0;
        checkCount++;
        if (got != 4) $display("FAIL const_count: got %0d results, expected 4", got);
        else passCount++;
    endtask

    task automatic test_midreset;
        logic [WIDTH-1:0]   s;
        logic [WIDTH-1:0]   di;
        logic               ci;
        logic               cyi;
        logic [2*WIDTH-1:0] e;
        int got;
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomAdd(s, di, ci, cyi);
            driveWord(s, di, ci, cyi);
            nextCycle();
        end
        bus.IN_VALID = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        checkCount++;
        if (bus.OUT_VALID !== 1'b0) $display("FAIL midrst_valid: got %b, expected 0", bus.OUT_VALID);
        else passCount++;
        checkCount++;
        if ({bus.CO, bus.O} !== '0) $display("FAIL midrst_data: got CO=%h O=%h, expected 0", bus.CO, bus.O);
        else passCount++;
        checkCount++;
        if (bus.IN_READY !== 1'b1) $display("FAIL midrst_ready: got %b, expected 1", bus.IN_READY);
        else passCount++;
        expQ.delete();
        @(negedge CLK) RST_N = 1'b1;
        randomAdd(s, di, ci, cyi);
        driveWord(s, di, ci, cyi);
        e = refModel(s, di, ci | cyi);
        #1;
        checkCount++;
        if (bus.IN_READY !== 1'b1) $display("FAIL midrst_first_accept: got IN_READY=%b, expected 1", bus.IN_READY);
        else passCount++;
        nextCycle();
        bus.IN_VALID = 1'b0;
        got = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (bus.OUT_VALID) begin
                checkCount++;
                if ({bus.CO, bus.O} !== e || cyc != NSEG - 1)
                    $display("FAIL midrst_output[%0d]: got CO=%h O=%h at cycle %0d, expected CO=%h O=%h at cycle %0d",
                             got, bus.CO, bus.O, cyc, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0], NSEG - 1);
                else passCount++;
                got++;
            end
            nextCycle();
        end
        checkCount++;
        if (got != 1) $display("FAIL midrst_count: got %0d results, expected 1", got);
        else passCount++;
    endtask

`ifdef CARRY_CASCADE_EN
    task automatic test_cascade;
        logic [WIDTH-1:0]   sArr  [10];
        logic [WIDTH-1:0]   dArr  [10];
        logic               ciArr [10];
        logic               cyArr [10];
        logic               chArr [10];
        logic [2*WIDTH-1:0] e;
        logic               prevCarry;
        int sent, got;
        sArr[0] = 16'hFFFE; dArr[0] = 16'hFFFF; ciArr[0] = 1'b0; cyArr[0] = 1'b0; chArr[0] = 1'b0;
        sArr[1] = 16'h0000; dArr[1] = 16'h0000; ciArr[1] = 1'b0; cyArr[1] = 1'b0; chArr[1] = 1'b1;
        for (int i = 2; i < 10; i++) begin
            randomAdd(sArr[i], dArr[i], ciArr[i], cyArr[i]);
            chArr[i] = 1'($urandom);
        end
        prevCarry = 1'b0;
        sent = 0; got = 0;
        expQ.delete();
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            if (sent < 10) begin
                driveWord(sArr[sent], dArr[sent], ciArr[sent], cyArr[sent]);
                bus.IN_CHAIN = chArr[sent];
            end else begin
                bus.IN_VALID = 1'b0;
                bus.IN_CHAIN = 1'b0;
            end
            #1;
            if (bus.OUT_VALID) begin
                checkCount++;
                if (expQ.size() == 0) $display("FAIL chain_extra: got CO=%h O=%h, expected no output", bus.CO, bus.O);
                else begin
                    e = expQ.pop_front();
                    if ({bus.CO, bus.O} !== e)
                        $display("FAIL chain_data[%0d]: got CO=%h O=%h, expected CO=%h O=%h",
                                 got, bus.CO, bus.O, e[2*WIDTH-1:WIDTH], e[WIDTH-1:0]);
                    else passCount++;
                end
                if (got == 1) begin
                    checkCount++;
                    if (bus.O !== 16'h0001) $display("FAIL chain_word2: got O=%h, expected 0001", bus.O);
                    else passCount++;
                end
                got++;
            end
            if (bus.IN_VALID) begin
                checkCount++;
                if (bus.IN_READY !== 1'b1) $display("FAIL chain_in_ready[%0d]: got %b, expected 1", cyc, bus.IN_READY);
                else passCount++;
                if (bus.IN_READY) begin
                    e = refModel(sArr[sent], dArr[sent], chArr[sent] ? prevCarry : (ciArr[sent] | cyArr[sent]));
                    prevCarry = e[2*WIDTH-1];
                    expQ.push_back(e);
                    sent++;
                end
            end
            nextCycle();
        end
        bus.IN_VALID = 1'b0;
        bus.IN_CHAIN = 1'b0;
        checkCount++;
        if (got != 10) $display("FAIL chain_count: got %0d results, expected 10", got);
        else passCount++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_streaming();
        test_backpressure();
        test_constants();
        test_midreset();
`ifdef CARRY_CASCADE_EN
        test_cascade();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
